// File: rtl/bitstream_pkg.sv
// Shared types and LFSR helpers for the stochastic sigmoid stages.
// The polynomial x^8+x^6+x^5+x^4+1 gives the maximal period of 255, and the LFSR never reaches zero.
package bitstream_pkg;

    typedef enum logic [1:0] {IDLE, WARM, RUN, DONE} seq_state_t;

    localparam logic [7:0] LFSR8_TAPS = 8'b1011_1000;

    // Fibonacci form: shift left, and the XOR of the tapped bits enters at bit 0.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR8_TAPS)};
    endfunction

endpackage

// File: rtl/sng8.sv
// Stochastic number generator: an 8-bit LFSR feeding a comparator, with a registered output bit.
// The output bit is forced to 0 whenever the generator is not enabled.
module sng8
    import bitstream_pkg::*;
#(
    parameter logic [7:0] RST_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] seed,
    input  logic [7:0] value,
    output logic       bit_out
);

    logic [7:0] lfsr_q, lfsr_d;
    logic       bit_q, bit_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (en) begin
            lfsr_d = lfsr8_next(lfsr_q);
        end
    end

    // The comparison uses the pre-advance state, so the first bit after a reload reflects the seed.
    assign bit_d = en && (lfsr_q < value);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lfsr_q <= RST_SEED;
            bit_q  <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            bit_q  <= bit_d;
        end
    end

    assign bit_out = bit_q;

endmodule

// File: rtl/power_seq_ctrl.sv
// Sequencer for one stochastic power unit. It streams an SNG bitstream out, skips the fill cycles,
// and counts the ones in the unit's output over a fixed window.
module power_seq_ctrl
    import bitstream_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned LENGTH = 255,
    parameter int unsigned WARMUP = 7,
    parameter logic [7:0]  SEED   = 8'hA5,
    localparam int unsigned CW    = $clog2(LENGTH + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    output logic             bs_x,
    input  logic             bs_y,
    output logic             bs_active,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count
);

    if (WIDTH != 8) begin : g_bad_width
        $error("power_seq_ctrl: only WIDTH=8 is supported");
    end
    if (LENGTH < 1) begin : g_bad_length
        $error("power_seq_ctrl: LENGTH must be at least 1");
    end
    if (SEED == 8'h00) begin : g_bad_seed
        $error("power_seq_ctrl: SEED must be nonzero");
    end

    // The phase counter is shared by WARM and RUN, so it is sized for the longer of the two phases.
    localparam int unsigned CNT_MAX = (LENGTH > WARMUP) ? LENGTH : WARMUP;
    localparam int unsigned CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNTW-1:0] WARM_LAST = CNTW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [CNTW-1:0] RUN_LAST  = CNTW'(LENGTH - 1);

    seq_state_t      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [7:0]      value_q, value_d;
    logic [CW-1:0]   count_q, count_d;
    logic            bs_active_q;
    logic            accept;
    logic            stream_en;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = (WARMUP == 0) ? RUN : WARM;
            WARM:    if (cnt_q == WARM_LAST) state_d = RUN;
            RUN:     if (cnt_q == RUN_LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        stream_en = (state_q == WARM) || (state_q == RUN);
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        cnt_d   = cnt_q;
        value_d = value_q;
        count_d = count_q;
        if (accept) begin
            cnt_d   = '0;
            value_d = in_value;
            count_d = '0;
        end else if (state_q == WARM) begin
            cnt_d = (cnt_q == WARM_LAST) ? '0 : cnt_q + CNTW'(1);
        end else if (state_q == RUN) begin
            cnt_d = (cnt_q == RUN_LAST) ? '0 : cnt_q + CNTW'(1);
            // The count is bounded by LENGTH, so it cannot wrap.
            if (bs_y) count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q       <= '0;
            value_q     <= '0;
            count_q     <= '0;
            bs_active_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            value_q     <= value_d;
            count_q     <= count_d;
            bs_active_q <= stream_en;
        end
    end

    sng8 #(
        .RST_SEED(SEED)
    ) u_sng (
        .clk    (clk),
        .n_rst  (n_rst),
        .load   (accept),
        .en     (stream_en),
        .seed   (SEED),
        .value  (value_q),
        .bit_out(bs_x)
    );

    // Registered alongside bs_x, so it marks exactly the cycles in which bs_x carries stream data.
    assign bs_active = bs_active_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_power_seq_ctrl.sv
// Directed bench for power_seq_ctrl: a vector table of requests in loopback or through a model
// power unit, plus sequences for backpressure, mid-run reset, and back-to-back requests.
module tb_power_seq_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_value = 8'd0;
    logic       bs_x;
    logic       bs_y;
    logic       bs_active;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_count;
    logic       loop_sel = 1'b1;

    logic [4:0] pu_d;
    logic       pu_y;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Power unit: y is x ANDed with five delayed copies of x, and the result is registered.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pu_d <= '0;
            pu_y <= 1'b0;
        end else begin
            pu_d <= {pu_d[3:0], bs_x};
            pu_y <= bs_x & (&pu_d);
        end
    end

    assign bs_y = loop_sel ? bs_x : pu_y;

    power_seq_ctrl dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_value (in_value),
        .bs_x     (bs_x),
        .bs_y     (bs_y),
        .bs_active(bs_active),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_count(out_count)
    );

    typedef struct {
        logic [7:0] value;
        bit         loop;
        int         exp_count;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Golden count for the power unit. Bit b[i] is (s_i < v), where s_0 is the seed.
    // The sample at RUN edge e is the AND of bits b[e-8] .. b[e-3], for e = 8..262.
    function automatic int pu_expect(input int v);
        bit   b[0:299];
        logic [7:0] s;
        int   n;
        s = 8'hA5;
        for (int i = 0; i < 300; i++) begin
            b[i] = (int'(s) < v);
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
        n = 0;
        for (int j = 0; j < 255; j++) begin
            bit a;
            a = 1'b1;
            for (int k = 0; k < 6; k++) a = a & b[j + k];
            if (a) n++;
        end
        return n;
    endfunction

    task automatic run_req(input logic [7:0] v, output int cnt, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        in_value = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 600) begin
            tick();
            lat++;
        end
        cnt = int'(out_count);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int cnt;
        int lat;
        int got;
        int cyc;
        int res[2];

        vecs[0] = '{value: 8'd128, loop: 1'b1, exp_count: 127};
        vecs[1] = '{value: 8'd255, loop: 1'b1, exp_count: 254};
        vecs[2] = '{value: 8'd0,   loop: 1'b1, exp_count: 0};
        vecs[3] = '{value: 8'd1,   loop: 1'b1, exp_count: 0};
        vecs[4] = '{value: 8'd2,   loop: 1'b1, exp_count: 1};
        vecs[5] = '{value: 8'd200, loop: 1'b1, exp_count: 199};
        vecs[6] = '{value: 8'd0,   loop: 1'b0, exp_count: 0};
        vecs[7] = '{value: 8'd255, loop: 1'b0, exp_count: pu_expect(255)};

        #23;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_bs_x", bs_x, 0);
        check("rst_bs_active", bs_active, 0);
        check("rst_out_count", out_count, 0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            loop_sel = vecs[i].loop;
            run_req(vecs[i].value, cnt, lat);
            check($sformatf("vec%0d_count", i), cnt, vecs[i].exp_count);
            check($sformatf("vec%0d_latency", i), lat, 263);
            release_result();
            check($sformatf("vec%0d_in_ready_after", i), in_ready, 1);
            check($sformatf("vec%0d_out_valid_after", i), out_valid, 0);
        end

        // Backpressure: the result holds while out_ready is low, and a stray request is ignored.
        loop_sel = 1'b1;
        run_req(8'd128, cnt, lat);
        check("bp_count", cnt, 127);
        for (int i = 0; i < 20; i++) begin
            in_valid = (i == 5);
            in_value = 8'd3;
            check("bp_out_valid", out_valid, 1);
            check("bp_out_count", out_count, 127);
            check("bp_in_ready", in_ready, 0);
            tick();
        end
        in_valid = 1'b0;
        release_result();
        check("bp_in_ready_after", in_ready, 1);
        check("bp_out_valid_after", out_valid, 0);
        check("bp_count_holds_idle", out_count, 127);
        tick();
        check("bp_still_idle", in_ready, 1);
        check("bp_bs_active_idle", bs_active, 0);

        // Asynchronous reset in the middle of RUN.
        in_value = 8'd128;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (100) tick();
        check("mid_bs_active", bs_active, 1);
        check("mid_in_ready", in_ready, 0);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_bs_x", bs_x, 0);
        check("arst_bs_active", bs_active, 0);
        check("arst_out_count", out_count, 0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        run_req(8'd128, cnt, lat);
        check("post_rst_count", cnt, 127);
        check("post_rst_latency", lat, 263);
        release_result();

        // Back-to-back requests with both handshakes held high.
        loop_sel = 1'b1;
        in_value = 8'd77;
        in_valid = 1'b1;
        out_ready = 1'b1;
        got = 0;
        cyc = 0;
        res[0] = -1;
        res[1] = -1;
        while (got < 2 && cyc < 1200) begin
            tick();
            cyc++;
            if (out_valid) begin
                res[got] = int'(out_count);
                got++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_results", got, 2);
        check("b2b_first", res[0], 76);
        check("b2b_second", res[1], 76);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
